stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-to-1 streaming multiplexer with a registered output and
//  valid/ready handshakes on every input and on the output.
//  Has two modes: direct select by the sel port, or round-robin arbitration.
//  Merges several producer streams onto a single consumer stream.
//  Next-generation replacement for our fixed-width, combinational 4:1 data mux.
// PARAMETERS
//  WIDTH   5                  data width per channel, >=1
//  NUM_CH  4                  number of input channels, >=2
//  SEL_W   $clog2(NUM_CH)     select/channel-index width (derived; do not override)
// PORTS
//  clk        in   1             single clock; all logic on posedge clk
//  rst_n      in   1             asynchronous, active-low reset
//  mode       in   1             0 = direct select (MODE_SEL), 1 = round-robin (MODE_RR)
//  sel        in   SEL_W         channel index, used only in MODE_SEL
//  in_data    in   NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   NUM_CH        per-channel valid
//  in_ready   out  NUM_CH        per-channel ready (combinational)
//  out_data   out  WIDTH         registered data
//  out_valid  out  1             registered valid
//  out_ch     out  SEL_W         index of the channel that supplied out_data
//  out_ready  in   1             consumer ready
// BEHAVIOUR
//  Reset (async assert, sync deassert at the next edge):
//   - out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1.
//   - Result: channel 0 has first priority after reset.
//  Load enable:
//   - load_en = !out_valid | out_ready.
//  Grant (combinational):
//   - MODE_SEL: grant=sel; grant_ok = in_valid[sel] & (sel<NUM_CH).
//     An out-of-range sel gives no grant, and all in_ready are 0.
//   - MODE_RR: first i with in_valid[i] set, searching from last_grant+1
//     upward and wrapping from NUM_CH-1 to 0. grant_ok = |in_valid.
//  Ready:
//   - in_ready[i] = load_en & grant_ok & (i==grant). At most one bit is high.
//  Transfer on channel i: in_valid[i] & in_ready[i]. At the next edge:
//   - out_data <= channel i data; out_ch <= i; out_valid <= 1.
//   - last_grant <= i. This applies in both modes, so switching to RR
//     continues fairly from the last served channel.
//  Drain without a load: out_valid & out_ready & no transfer -> out_valid <= 0.
//  Simultaneous drain and load: the register is replaced and out_valid stays 1.
//   - This sustains 1 word per cycle with no bubble.
//  Latency: 1 cycle from input transfer to out_valid.
//  Throughput: 1 word per cycle while out_ready=1.
//  Backpressure: while out_valid & !out_ready, out_data, out_ch and
//   out_valid hold their values, and all in_ready are 0.
//  No combinational path from in_valid, sel or mode to any output register.
//   - The only combinational paths are in_valid/sel/mode/out_ready -> in_ready.
//  mode or sel changes take effect in the same cycle's grant. They never
//   corrupt a word already held in the output register.
//  Reset asserted mid-transfer: the held word is discarded, out_valid drops
//   immediately, and last_grant returns to NUM_CH-1.
//  RR fairness: with all channels valid, grants rotate 0,1,..,NUM_CH-1,0.
//   - No channel waits more than NUM_CH-1 transfers while valid.
// STRUCTURE
//  Package mux_pkg holds:
//   - localparams MODE_SEL=1'b0 and MODE_RR=1'b1.
//   - a function rr_pick(valid, last) returning the next index, reused by other arbiters.
//  Sub-module rr_arbiter #(NUM_CH):
//   - Inputs: req, last_grant. Outputs: grant, grant_ok.
//   - Purely combinational; no other sub-modules.
//  Top level holds:
//   - mode/sel grant mux
//   - last_grant register
//   - output register and in_ready decode
// TESTING (WIDTH=5, NUM_CH=4 unless stated)
//  1 Reset/hold:
//   - stimulus: rst_n=0 with random inputs.
//   - response: out_valid=0, out_data=0, out_ch=0 and in_ready=0000, held for 3 cycles.
//  2 MODE_SEL sweep:
//   - stimulus: data 4,5,6,7 on ch0..3, all valid, out_ready=1, sel stepping 0..3 each cycle.
//   - response: out_data=4,5,6,7 and out_ch=0..3, each one cycle after its sel.
//  3 MODE_RR rotation:
//   - stimulus: all valid, out_ready=1.
//   - response: out_ch=0,1,2,3,0,1 on consecutive cycles; in_valid=1010 yields 1,3,1,3.
//  4 Backpressure:
//   - stimulus: out_ready=0 for 4 cycles with a word held, then out_ready=1.
//   - response: out_data stable and in_ready=0 during the stall, no word lost or
//     duplicated, next word one cycle after release.
//  5 Boundary:
//   - stimulus: NUM_CH=3 with sel=3.
//   - response: no grant, and out_valid falls after a drain.
//   - stimulus: switch mode 0->1 after serving ch2.
//   - response: next RR grant is ch3 (or wraps to ch0).
//  6 Mid-stream reset:
//   - stimulus: rst_n pulsed low between edges while out_valid=1.
//   - response: out_valid=0 immediately; first grant after release is ch0 in MODE_RR.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: mode encodings and a reusable round-robin pick function
// Holds MODE_SEL/MODE_RR and rr_pick(valid, last, n), which returns the first
// set index of valid[n-1:0] searching upward from last+1 with wrap to 0.
package mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int RR_MAX = 32;
  localparam int RR_IDX_W = 5;
  // Scans from the farthest candidate back to the nearest, so the last hit is
  // the first requester after last; n is a constant at every call site.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                  input logic [RR_IDX_W-1:0] last,
                                                  input int n);
    logic [RR_IDX_W-1:0] idx;
    rr_pick = last;
    for (int k = RR_MAX; k >= 1; k--) begin
      idx = RR_IDX_W'((int'(last) + k) % n);
      if (k <= n && valid[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter over NUM_CH requesters
// Ports: req (requests), last_grant (previously served index),
//        grant (chosen index), grant_ok (any request present).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_ok
);
  always_comb begin
    grant = SEL_W'(rr_pick(RR_MAX'(req), RR_IDX_W'(last_grant), NUM_CH));
    grant_ok = |req;
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux with registered output, direct-select or round-robin
// Ports: clk, rst_n (async active-low); mode (0 sel, 1 rr); sel (channel in sel mode);
//        in_data/in_valid/in_ready (per-channel streams, channel i at [i*WIDTH +: WIDTH]);
//        out_data/out_valid/out_ch (registered output word and source channel); out_ready.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NUM_CH = 4,
  parameter int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(NUM_CH);
  logic [SEL_W-1:0] last_grant, rr_grant, grant;
  logic rr_ok, sel_ok, grant_ok, load_en, take;
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (in_valid),
    .last_grant(last_grant),
    .grant     (rr_grant),
    .grant_ok  (rr_ok)
  );
  // rst_n gates the handshake so no producer sees ready while reset is held.
  always_comb begin
    load_en = !out_valid || out_ready;
    sel_ok = {1'b0, sel} < NCH;
    grant = (mode == MODE_RR) ? rr_grant : sel;
    grant_ok = (mode == MODE_RR) ? rr_ok : (sel_ok && in_valid[sel]);
    take = rst_n && load_en && grant_ok;
    in_ready = take ? NUM_CH'(1) << grant : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data <= in_data[grant*WIDTH +: WIDTH];
      out_ch <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: self-checking bench with vector table, reference model and scoreboard
module tb_stream_mux_rr;
  localparam int W = 5;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic out_valid;
  logic [1:0] out_ch;
  logic mode3 = 1'b0;
  logic ordy3 = 1'b1;
  logic [1:0] sel3 = '0;
  logic [3*W-1:0] data3 = {5'd12, 5'd11, 5'd10};
  logic [2:0] valid3 = '0;
  logic [2:0] ready3;
  logic [W-1:0] odata3;
  logic ov3;
  logic [1:0] och3;
  stream_mux_rr #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
  );
  stream_mux_rr #(.WIDTH(W), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(data3),
    .in_valid(valid3), .in_ready(ready3), .out_data(odata3),
    .out_valid(ov3), .out_ch(och3), .out_ready(ordy3)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] d;
    logic [1:0] ch;
  } word_t;
  typedef struct {
    logic m;
    logic [1:0] s;
    logic [3:0] v;
    logic [1:0] ech;
  } vec_t;
  word_t sb[$];
  int checks = 0;
  int failures = 0;
  bit mv = 1'b0;
  int mlast = N - 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic int exp_grant(input bit m, input logic [1:0] s, input logic [3:0] v,
                                   input int last, output bit ok);
    if (!m) begin
      ok = v[s];
      return int'(s);
    end
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) begin
        ok = 1'b1;
        return i;
      end
    end
    ok = 1'b0;
    return 0;
  endfunction
  // One clock of the main DUT: inputs already applied after the previous edge.
  task automatic step();
    int g;
    bit ok;
    bit xfer;
    word_t w;
    @(negedge clk);
    g = exp_grant(mode, sel, in_valid, mlast, ok);
    xfer = rst_n && (!mv || out_ready) && ok;
    chk("in_ready", 32'(in_ready), xfer ? 32'(1) << g : 32'(0));
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (mv && sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow actual=out_valid expected=no_word");
    end else if (mv) begin
      if (out_ready) begin
        w = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(w.d));
        chk("out_ch", 32'(out_ch), 32'(w.ch));
      end else begin
        chk("hold_data", 32'(out_data), 32'(sb[0].d));
      end
    end
    if (xfer) sb.push_back('{d: in_data[g*W +: W], ch: 2'(g)});
    @(posedge clk);
    if (xfer) begin
      mv = 1'b1;
      mlast = g;
    end else if (out_ready) mv = 1'b0;
    #1;
  endtask
  vec_t tbl[22];
  initial begin
    tbl = '{
      '{0, 0, 4'hF, 0}, '{0, 1, 4'hF, 1}, '{0, 2, 4'hF, 2}, '{0, 3, 4'hF, 3},
      '{1, 0, 4'hF, 0}, '{1, 0, 4'hF, 1}, '{1, 0, 4'hF, 2}, '{1, 0, 4'hF, 3},
      '{1, 0, 4'hF, 0}, '{1, 0, 4'hF, 1}, '{1, 0, 4'hF, 2}, '{1, 0, 4'hF, 3},
      '{1, 0, 4'hF, 0},
      '{1, 0, 4'hA, 1}, '{1, 0, 4'hA, 3}, '{1, 0, 4'hA, 1}, '{1, 0, 4'hA, 3},
      '{0, 2, 4'hF, 2}, '{1, 0, 4'hF, 3}, '{1, 0, 4'h1, 0},
      '{0, 1, 4'h2, 1}, '{1, 0, 4'hC, 2}
    };
    for (int c = 0; c < 3; c++) begin
      mode = 1'($urandom);
      sel = 2'($urandom);
      in_valid = 4'($urandom) | 4'h1;
      out_ready = 1'($urandom);
      in_data = N*W'($urandom);
      valid3 = 3'h7;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_ready3", 32'(ready3), 0);
    end
    in_valid = '0;
    valid3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_data = {5'd7, 5'd6, 5'd5, 5'd4};
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      mode = tbl[i].m;
      sel = tbl[i].s;
      in_valid = tbl[i].v;
      step();
      chk($sformatf("tbl%0d_ch", i), 32'(out_ch), 32'(tbl[i].ech));
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ech) + 4);
    end
    in_valid = '0;
    step();
    chk("drain_valid", 32'(out_valid), 0);
    mode = 1'b1;
    in_valid = 4'hF;
    step();
    chk("bp_load_ch", 32'(out_ch), 3);
    out_ready = 1'b0;
    repeat (4) begin
      step();
      chk("bp_hold_data", 32'(out_data), 7);
      chk("bp_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ch", 32'(out_ch), 0);
    chk("bp_release_data", 32'(out_data), 4);
    in_valid = '0;
    step();
    valid3 = 3'h7;
    sel3 = 2'd0;
    step();
    chk("n3_load_valid", 32'(ov3), 1);
    chk("n3_load_data", 32'(odata3), 10);
    sel3 = 2'd3;
    #1;
    chk("n3_oor_ready", 32'(ready3), 0);
    step();
    chk("n3_oor_drain", 32'(ov3), 0);
    sel3 = 2'd2;
    #1;
    chk("n3_sel2_ready", 32'(ready3), 3'b100);
    step();
    chk("n3_sel2_ch", 32'(och3), 2);
    mode3 = 1'b1;
    #1;
    chk("n3_rr_wrap_ready", 32'(ready3), 3'b001);
    step();
    chk("n3_rr_wrap_ch", 32'(och3), 0);
    valid3 = '0;
    mode = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b0;
    step();
    chk("mid_load_valid", 32'(out_valid), 1);
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    sb.delete();
    mv = 1'b0;
    mlast = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    step();
    chk("mid_first_ch", 32'(out_ch), 0);
    repeat (80) begin
      mode = 1'($urandom);
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      in_data = N*W'($urandom);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("sb_left", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
